// File: rtl/raster_pkg.sv
// Shared raster definitions: default geometry and the bounding-box walker states.
package raster_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } walk_state_t;

endpackage

// File: rtl/minmax3.sv
// Combinational minimum and maximum of three unsigned values.
module minmax3 #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] a,
    input  logic [COORD_W-1:0] b,
    input  logic [COORD_W-1:0] c,
    output logic [COORD_W-1:0] min_val,
    output logic [COORD_W-1:0] max_val
);

    logic [COORD_W-1:0] ab_min;
    logic [COORD_W-1:0] ab_max;

    always_comb begin
        ab_min  = (a < b) ? a : b;
        ab_max  = (a > b) ? a : b;
        min_val = (c < ab_min) ? c : ab_min;
        max_val = (c > ab_max) ? c : ab_max;
    end

endmodule

// File: rtl/bbox_walker.sv
// Walks the bounding box of a triangle in raster order, one candidate pixel per handshake.
// Optional SCREEN_CLIP_EN clamps the box to the screen and may produce an empty walk.
module bbox_walker
    import raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF
) (
    input  logic               clk_pix,
    input  logic               reset,
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic               start,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last,
    output logic               done
);

`ifdef SCREEN_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES - 1);

    walk_state_t state, state_nx;

    logic [COORD_W-1:0] vax, vay, vbx, vby, vcx, vcy;
    logic [COORD_W-1:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;
    logic [COORD_W-1:0] clip_xmax, clip_ymax;
    logic [COORD_W-1:0] xmin, xmax, ymax;
    logic               box_empty;
    logic               accept, load, step, at_last;

    minmax3 #(.COORD_W(COORD_W)) u_minmax_x (
        .a       (vax),
        .b       (vbx),
        .c       (vcx),
        .min_val (raw_xmin),
        .max_val (raw_xmax)
    );

    minmax3 #(.COORD_W(COORD_W)) u_minmax_y (
        .a       (vay),
        .b       (vby),
        .c       (vcy),
        .min_val (raw_ymin),
        .max_val (raw_ymax)
    );

    // Clamping only ever lowers the max, so only the max side can cross the min.
    always_comb begin
        clip_xmax = raw_xmax;
        clip_ymax = raw_ymax;
        if (CLIP_EN && (raw_xmax > X_LIM)) clip_xmax = X_LIM;
        if (CLIP_EN && (raw_ymax > Y_LIM)) clip_ymax = Y_LIM;
        box_empty = CLIP_EN && ((raw_xmin > clip_xmax) || (raw_ymin > clip_ymax));
    end

    always_comb begin
        at_last = (x == xmax) && (y == ymax);
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (box_empty) begin
                    state_nx = DONE;
                end else begin
                    load     = 1'b1;
                    state_nx = WALK;
                end
            end
            WALK: begin
                if (out_ready) begin
                    step = 1'b1;
                    if (at_last) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            vax  <= '0;
            vay  <= '0;
            vbx  <= '0;
            vby  <= '0;
            vcx  <= '0;
            vcy  <= '0;
            xmin <= '0;
            xmax <= '0;
            ymax <= '0;
            x    <= '0;
            y    <= '0;
        end else begin
            if (accept) begin
                vax <= ax;
                vay <= ay;
                vbx <= bx;
                vby <= by;
                vcx <= cx;
                vcy <= cy;
            end
            if (load) begin
                xmin <= raw_xmin;
                xmax <= clip_xmax;
                ymax <= clip_ymax;
                x    <= raw_xmin;
                y    <= raw_ymin;
            end else if (step && !at_last) begin
                if (x < xmax) begin
                    x <= x + 1'b1;
                end else begin
                    x <= xmin;
                    y <= y + 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == WALK);
        last      = (state == WALK) && at_last;
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_bbox_walker.sv
// Directed self-checking bench for bbox_walker (default build, or with SCREEN_CLIP_EN).
module tb_bbox_walker;

    logic       clk_pix = 1'b0;
    logic       reset;
    logic       start;
    logic       out_ready;
    logic [9:0] ax, ay, bx, by, cx, cy;
    logic       busy, out_valid, last, done;
    logic [9:0] x, y;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] qx[$];
    logic [9:0] qy[$];
    logic       ql[$];
    int         first_valid_cyc, done_cyc, last_hs_cyc, done_pulses, stall_errs;
    logic       busy_after_done;
    logic       timed_out;

    always #5 clk_pix = ~clk_pix;

    bbox_walker #(
        .COORD_W (10),
        .H_RES   (640),
        .V_RES   (480)
    ) dut (
        .clk_pix   (clk_pix),
        .reset     (reset),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .cx        (cx),
        .cy        (cy),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .last      (last),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic set_tri(input int a_x, input int a_y, input int b_x, input int b_y,
                           input int c_x, input int c_y);
        ax = 10'(a_x); ay = 10'(a_y);
        bx = 10'(b_x); by = 10'(b_y);
        cx = 10'(c_x); cy = 10'(c_y);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records accepted pixels, stall stability and done timing; cycle 1 is the cycle after accept.
    task automatic collect(input logic [3:0] rpat, input logic start_on_done, input int maxc);
        logic [9:0] hx, hy;
        logic       hl;
        logic       held;
        logic       seen_done;
        held = 1'b0;
        seen_done = 1'b0;
        hx = '0; hy = '0; hl = 1'b0;
        qx.delete(); qy.delete(); ql.delete();
        first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
        done_pulses = 0; stall_errs = 0; timed_out = 1'b1; busy_after_done = 1'b1;
        for (int cyc = 1; cyc <= maxc; cyc++) begin
            out_ready = rpat[cyc % 4];
            if (held && (x !== hx || y !== hy || last !== hl || out_valid !== 1'b1))
                stall_errs++;
            held = 1'b0;
            if (seen_done) begin
                busy_after_done = busy;
                start = 1'b0;
                if (done) done_pulses++;
                timed_out = 1'b0;
                break;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                qx.push_back(x); qy.push_back(y); ql.push_back(last);
                if (last) last_hs_cyc = cyc;
            end else if (out_valid) begin
                held = 1'b1; hx = x; hy = y; hl = last;
            end
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
                seen_done = 1'b1;
                if (start_on_done) start = 1'b1;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    // Index of the first pixel deviating from raster order over the given box, -1 if none.
    function automatic int first_bad(input int xlo, input int xhi, input int ylo, input int yhi);
        int w;
        int n;
        w = xhi - xlo + 1;
        n = w * (yhi - ylo + 1);
        if (qx.size() != n) return n;
        for (int i = 0; i < n; i++) begin
            if (int'(qx[i]) != xlo + i % w || int'(qy[i]) != ylo + i / w || ql[i] !== (i == n - 1))
                return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        int vcount;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        set_tri(0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_checks++;
        if ({busy, out_valid, last, done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, out_valid, last, done});
        end
        n_checks++;
        if ({x, y} !== 20'd0) begin
            n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d want 0,0", x, y);
        end
        #2 reset = 1'b0;
        vcount = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid || busy) vcount++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL post_reset_idle: got %0d active cycles want 0", vcount);
        end
    endtask

    task automatic test_basic();
        int bad;
        set_tri(10, 20, 12, 20, 10, 21);
        do_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy: got %b want 1", busy);
        end
        collect(4'b1111, 1'b0, 40);
        bad = first_bad(10, 12, 20, 21);
        n_checks++;
        if (timed_out !== 1'b0 || bad !== -1) begin
            n_fail++; $display("FAIL basic_seq: timeout=%b bad_index=%0d count=%0d want 6 in order", timed_out, bad, qx.size());
        end
        n_checks++;
        if (first_valid_cyc !== 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 2", first_valid_cyc);
        end
        n_checks++;
        if (done_cyc !== last_hs_cyc + 1 || done_pulses !== 1) begin
            n_fail++; $display("FAIL basic_done: done_cyc=%0d last_cyc=%0d pulses=%0d want last+1, 1 pulse", done_cyc, last_hs_cyc, done_pulses);
        end
        n_checks++;
        if (busy_after_done !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy_after_done);
        end
    endtask

    task automatic test_degenerate();
        set_tri(5, 5, 5, 5, 5, 5);
        do_start();
        collect(4'b1111, 1'b0, 20);
        n_checks++;
        if (qx.size() !== 1 || qx[0] !== 10'd5 || qy[0] !== 10'd5 || ql[0] !== 1'b1) begin
            n_fail++; $display("FAIL degen_pixel: count=%0d x=%0d y=%0d last=%b want 1 pixel (5,5) last=1", qx.size(), qx.size() ? qx[0] : 10'd0, qx.size() ? qy[0] : 10'd0, qx.size() ? ql[0] : 1'b0);
        end
        n_checks++;
        if (first_valid_cyc !== 2 || done_cyc !== 3) begin
            n_fail++; $display("FAIL degen_timing: first=%0d done=%0d want 2,3", first_valid_cyc, done_cyc);
        end
    endtask

    task automatic test_stall();
        int bad;
        set_tri(10, 20, 12, 20, 10, 21);
        do_start();
        collect(4'b1001, 1'b0, 60);
        bad = first_bad(10, 12, 20, 21);
        n_checks++;
        if (timed_out !== 1'b0 || bad !== -1) begin
            n_fail++; $display("FAIL stall_seq: timeout=%b bad_index=%0d count=%0d want 6 in order", timed_out, bad, qx.size());
        end
        n_checks++;
        if (stall_errs !== 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_errs);
        end
        n_checks++;
        if (done_cyc !== last_hs_cyc + 1) begin
            n_fail++; $display("FAIL stall_done: done_cyc=%0d want %0d", done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_reset_midwalk();
        int vcount;
        set_tri(10, 20, 12, 20, 10, 21);
        do_start();
        out_ready = 1'b1;
        tick();
        start = 1'b1;
        set_tri(0, 0, 1, 1, 2, 2);
        tick();
        start = 1'b0;
        n_checks++;
        if (x !== 10'd11 || y !== 10'd20) begin
            n_fail++; $display("FAIL restart_ignored: got (%0d,%0d) want (11,20)", x, y);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || x !== 10'd12 || y !== 10'd20) begin
            n_fail++; $display("FAIL third_pixel: valid=%b (%0d,%0d) want 1 (12,20)", out_valid, x, y);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, last, done} !== 4'b0000 || {x, y} !== 20'd0) begin
            n_fail++; $display("FAIL async_reset: flags=%b x=%0d y=%0d want 0000,0,0", {out_valid, busy, last, done}, x, y);
        end
        #2 reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid || busy) vcount++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL midwalk_idle: got %0d active cycles want 0", vcount);
        end
    endtask

    task automatic test_back_to_back();
        int vcount;
        set_tri(10, 20, 12, 20, 10, 21);
        do_start();
        collect(4'b1111, 1'b1, 40);
        n_checks++;
        if (busy_after_done !== 1'b0 || qx.size() !== 6) begin
            n_fail++; $display("FAIL start_in_done: busy=%b count=%0d want 0,6", busy_after_done, qx.size());
        end
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid || busy) vcount++;
        end
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL done_start_leak: got %0d active cycles want 0", vcount);
        end
    endtask

`ifdef SCREEN_CLIP_EN
    task automatic test_clip();
        int bad;
        set_tri(630, 470, 700, 500, 650, 479);
        do_start();
        collect(4'b1111, 1'b0, 200);
        bad = first_bad(630, 639, 470, 479);
        n_checks++;
        if (timed_out !== 1'b0 || bad !== -1) begin
            n_fail++; $display("FAIL clip_seq: timeout=%b bad_index=%0d count=%0d want 100 in order", timed_out, bad, qx.size());
        end
        set_tri(700, 10, 700, 10, 700, 10);
        do_start();
        collect(4'b1111, 1'b0, 20);
        n_checks++;
        if (qx.size() !== 0 || done_pulses !== 1 || done_cyc !== 2) begin
            n_fail++; $display("FAIL clip_empty: count=%0d pulses=%0d done_cyc=%0d want 0,1,2", qx.size(), done_pulses, done_cyc);
        end
    endtask
`else
    task automatic test_noclip();
        int bad;
        set_tri(638, 0, 641, 0, 638, 0);
        do_start();
        collect(4'b1111, 1'b0, 20);
        bad = first_bad(638, 641, 0, 0);
        n_checks++;
        if (timed_out !== 1'b0 || bad !== -1) begin
            n_fail++; $display("FAIL noclip_seq: timeout=%b bad_index=%0d count=%0d want 4 (638..641)", timed_out, bad, qx.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_degenerate();
        test_stall();
        test_reset_midwalk();
        test_back_to_back();
`ifdef SCREEN_CLIP_EN
        test_clip();
`else
        test_noclip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
